// File: rtl/shift_add_mult.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// shift_add_mult
//   Sequential 32x32 -> 64 unsigned multiplier using the classic shift-add
//   algorithm. The 32-bit addition is borrowed from an external combinational
//   carry-lookahead adder; this block only sequences operands and shifts.
//
// Ports
//   clk          single clock, rising-edge state updates
//   reset_n      asynchronous active-low reset
//   start_valid  operands valid (accepted in IDLE)
//   start_ready  block can accept operands (registered)
//   op_a, op_b   multiplicand / multiplier, unsigned 32-bit
//   add_a/add_b  operands driven to the external adder
//   add_cin      carry-in driven to the external adder (always 0)
//   add_sum      sum returned by the external adder
//   add_cout     per-bit carry vector from the adder; only bit 31 is used
//   res_valid    product valid (registered)
//   res_ready    consumer accepts product
//   product      64-bit unsigned product (registered)
//
// Timing
//   Start handshake at edge k -> 32 RUN steps on edges k+1..k+32 -> state DONE
//   at edge k+32. res_valid and product are registered from DONE, so they are
//   visible from edge k+33 and the DONE->IDLE handshake is qualified with the
//   registered res_valid. start_ready rises on the handshake edge, i.e. in the
//   cycle after res_valid was last seen high, so result and accept never
//   overlap.
// -----------------------------------------------------------------------------
module shift_add_mult (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic [31:0] add_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic [31:0] acc_r;        // A: upper half of the running product
  logic [31:0] mplr_r;       // Q: multiplier, shifted out as product bits shift in
  logic [31:0] mcand_r;      // M: latched multiplicand
  logic [4:0]  cnt_r;        // step counter, 0..31

  logic        start_ready_r;
  logic        res_valid_r;
  logic [63:0] product_r;

  logic        accept_s;
  logic        last_step_s;
  logic        deliver_s;

  // Only the top carry matters; the lower carries are consumed here so the
  // unused bits are explicit rather than silently dropped.
  logic        unused_cout_s;
  assign unused_cout_s = &{1'b0, add_cout[30:0]};

  assign accept_s    = (state_r == ST_IDLE) && start_valid;
  assign last_step_s = (state_r == ST_RUN) && (cnt_r == 5'd31);
  assign deliver_s   = (state_r == ST_DONE) && res_valid_r && res_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_step_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (deliver_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Adder operand drive: only RUN uses the adder, everything else is quiet.
  always_comb begin
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b0;
    if (state_r == ST_RUN) begin
      add_a = acc_r;
      add_b = mplr_r[0] ? mcand_r : 32'd0;
    end else begin
      add_a = 32'd0;
      add_b = 32'd0;
    end
  end

  // Shift-add datapath: {cout, sum} is the 33-bit partial sum, shifted right
  // by one into {A, Q}. The adder carry lands in A[31], so no overflow is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r   <= 32'd0;
      mplr_r  <= 32'd0;
      mcand_r <= 32'd0;
      cnt_r   <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mcand_r <= op_a;
            mplr_r  <= op_b;
            acc_r   <= 32'd0;
            cnt_r   <= 5'd0;
          end else begin
            mcand_r <= mcand_r;
            mplr_r  <= mplr_r;
            acc_r   <= acc_r;
            cnt_r   <= cnt_r;
          end
        end
        ST_RUN: begin
          acc_r  <= {add_cout[31], add_sum[31:1]};
          mplr_r <= {add_sum[0], mplr_r[31:1]};
          cnt_r  <= cnt_r + 5'd1;
        end
        default: begin
          acc_r   <= acc_r;
          mplr_r  <= mplr_r;
          mcand_r <= mcand_r;
          cnt_r   <= cnt_r;
        end
      endcase
    end
  end

  // Registered handshake flags and result.
  // res_valid goes high one edge after entering DONE and drops on delivery;
  // product is captured from {A, Q} only in DONE so it is frozen there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_ready_r <= 1'b1;
      res_valid_r   <= 1'b0;
      product_r     <= 64'd0;
    end else begin
      start_ready_r <= (state_nxt_s == ST_IDLE);
      res_valid_r   <= (state_r == ST_DONE) && (state_nxt_s == ST_DONE);
      if (state_r == ST_DONE) begin
        product_r <= {acc_r, mplr_r};
      end else begin
        product_r <= product_r;
      end
    end
  end

  assign start_ready = start_ready_r;
  assign res_valid   = res_valid_r;
  assign product     = product_r;

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits, matching the team's 32-bit carry-lookahead adder.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 start_valid  input  1  operands valid.
REQ-005 start_ready  output  1  block can accept operands.
REQ-006 op_a  input  32  multiplicand, unsigned.
REQ-007 op_b  input  32  multiplier, unsigned.
REQ-008 add_a  output  32  adder operand A.
REQ-009 add_b  output  32  adder operand B.
REQ-010 add_cin  output  1  adder carry-in.
REQ-011 add_sum  input  32  adder sum.
REQ-012 add_cout  input  32  adder per-bit carry vector; only bit 31 is used.
REQ-013 res_valid  output  1  product valid.
REQ-014 res_ready  input  1  consumer accepts product.
REQ-015 product  output  64  unsigned op_a*op_b.

Function
REQ-016 The external adder is combinational: add_sum and add_cout respond to add_a/add_b/add_cin within the same cycle.
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: start_ready=1 and res_valid=0.
REQ-019 IDLE: start_valid=1 at an edge -> latch M=op_a and Q=op_b, clear A=0 and cnt=0, go to RUN.
REQ-020 RUN: add_a=A, add_b=(Q[0] ? M : 0), add_cin=0.
REQ-021 RUN, each edge: A <= {add_cout[31], add_sum[31:1]}, Q <= {add_sum[0], Q[31:1]}, cnt <= cnt+1.
REQ-022 RUN lasts exactly 32 cycles; the edge with cnt==31 moves to DONE.
REQ-023 Latency: with the start handshake at edge k, res_valid is 1 from edge k+33.
REQ-024 DONE: res_valid=1 and product={A,Q}; product holds stable while res_ready=0.
REQ-025 DONE with res_ready=1 at an edge -> IDLE; start_ready rises the following cycle (no overlap of result and new accept).
REQ-026 Outside RUN: add_a=0, add_b=0, add_cin=0.
REQ-027 start_ready=0 in RUN and DONE; start_valid and op_a/op_b are ignored there.
REQ-028 op_a/op_b changes after the start handshake do not affect the result.
REQ-029 product is valid only while res_valid=1; its value outside DONE is don't-care but deterministic.
REQ-030 Carry handling: a full-width overflow (add_cout[31]=1) is never lost; 0xFFFFFFFF*0xFFFFFFFF is exact.

Reset
REQ-031 reset_n=0 forces, asynchronously:
- state=IDLE
- A, Q, M, cnt = 0
- start_ready=1, res_valid=0, product=0
- add_a=0, add_b=0, add_cin=0
REQ-032 Reset asserted mid-RUN or mid-DONE aborts the operation; no res_valid pulse follows reset release.
REQ-033 The first start handshake is possible at the first rising edge after reset_n deasserts.

Verification
REQ-034 op_a=3, op_b=5, res_ready=1 -> res_valid at handshake edge+33, product=0x0000_0000_0000_000F, start_ready=1 one cycle later.
REQ-035 op_a=op_b=0xFFFFFFFF -> product=0xFFFFFFFE_00000001.
REQ-036 op_a=0x12345678, op_b=0 -> product=0; op_a=0, op_b=0xDEADBEEF -> product=0.
REQ-037 Back-pressure: res_ready=0 for 10 cycles in DONE -> res_valid and product held for all 10 cycles; one handshake on release.
REQ-038 start_valid=1 with new operands during RUN -> ignored; first result is unchanged and one product is produced per accepted start.
REQ-039 reset_n pulsed low at RUN cycle 16 -> all outputs at reset values immediately; a new 7*9 operation afterwards gives 63.
